iic_arbiter: RTL and testbench
==============================

Name: iic_arbiter

Overview:
Two-port request arbiter that shares one iic_ctrl instance (single SCL/SDA master) between requesters. Port 0 is the boot-time WM8978 register sequencer; port 1 is a runtime client such as a volume/mute control. Requests are accepted with a valid/ready handshake and launched as a one-cycle wr_en/rd_en pulse. Command fields are held stable until iic_ctrl's done_flag. Completion and read data are routed back to the owning port.

Parameters:
ADDR_W, 16, width of register-address field (iic_ctrl uses [7:0] when addr_num=0)
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties
GAP_CYCLES, 4, idle clk cycles forced between consecutive transactions (bus free time), range 0..255
TIMEOUT_CYC, 1000000, BUSY watchdog limit in clk cycles (used only with optional feature)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset; top drives iic_ctrl rst_n with ~rst
req0_valid / req1_valid  in  1  request pending; held with fields until readyN
req0_rd / req1_rd  in  1  1 = read, 0 = write
req0_dev_addr / req1_dev_addr  in  7  7-bit device address
req0_addr / req1_addr  in  ADDR_W  register address
req0_addr_num / req1_addr_num  in  1  0 = 1-byte address, 1 = 2-byte address
req0_wdata / req1_wdata  in  8  write data
req0_ready / req1_ready  out  1  one-cycle accept pulse
req0_done / req1_done  out  1  one-cycle completion pulse
req0_rdata / req1_rdata  out  8  read data, valid from doneN, held until next read on that port
timeout_err  out  1  one-cycle pulse with a done that ended by watchdog
iic_wr_en / iic_rd_en  out  1  one-cycle launch pulses to iic_ctrl
iic_dev_addr  out  7  latched device address
iic_addr  out  ADDR_W  latched register address
iic_addr_num  out  1  latched address-byte count
iic_data  out  8  latched write data
iic_done_flag  in  1  one-cycle completion pulse from iic_ctrl
iic_rd_data  in  8  read result, valid when iic_done_flag=1

Behaviour:
- Reset: state=IDLE; all outputs 0; last_grant=1, so port 0 wins the first tie; gap counter=0. Reset mid-transaction aborts with no done pulse; iic_ctrl is reset by the same event.
- FSM: IDLE -> ISSUE -> BUSY -> GAP -> IDLE.
- IDLE: if any valid, select a winner, pulse its readyN, and latch its fields into iic_* and owner. Cycle T.
- Tie-break: FIXED_PRIO=0 picks the port other than last_grant. FIXED_PRIO=1 picks port 0. Single valid wins regardless.
- ISSUE (T+1): pulse iic_rd_en if latched rd=1, else iic_wr_en. Exactly one cycle, never both.
- BUSY: iic_* fields held constant. On iic_done_flag (cycle D): capture iic_rd_data into owner's rdata if read. Pulse owner's doneN at D+1. Update last_grant=owner. Load gap counter=GAP_CYCLES.
- GAP: decrement to 0, then IDLE. GAP_CYCLES=0 returns to IDLE the cycle after done. No ready pulses during ISSUE/BUSY/GAP.
- Minimum accept-to-accept spacing = (D−T) + 1 + GAP_CYCLES + 1 cycles.
- iic_done_flag outside BUSY is ignored.
- valid dropped before ready: nothing launched, no state change.
- Requester must not change fields while valid=1 and ready=0. Fields are don't-care after ready.
- rdata of the non-owner port never changes.

Optional Feature:
Macro IIC_ARB_TIMEOUT_EN.
- Defined: a 20-bit-min counter runs in BUSY. At TIMEOUT_CYC cycles without done_flag, the FSM pulses owner's doneN and timeout_err together, leaves rdata unchanged, and enters GAP. A late done_flag is then ignored.
- Undefined: BUSY waits indefinitely; timeout_err tied 0; no counter logic.

Test Plan:
- Port 0 write dev=0x1A addr=0x00 data=0x5C; model done 40 cycles after wr_en -> ready0 at T, iic_wr_en at T+1 with fields 0x1A/0x00/0x5C, done0 one cycle after done_flag, iic_rd_en never high.
- Port 1 read addr=0x0102 addr_num=1; model returns 0xA7 -> iic_rd_en single pulse, req1_rdata=0xA7 at done1, req0_rdata unchanged.
- Both valid from reset, FIXED_PRIO=0, GAP_CYCLES=4 -> grants 0,1,0,1; ≥4 idle cycles between done and next ready; FIXED_PRIO=1 -> port 0 served until req0_valid drops.
- Spurious iic_done_flag in IDLE/GAP; rst asserted mid-BUSY -> no done pulses; all outputs 0 during reset; next request after release goes to port 0.
- IIC_ARB_TIMEOUT_EN, TIMEOUT_CYC=100, model never responds -> done0 and timeout_err pulse together at 100 BUSY cycles; late done_flag ignored. Without macro -> stays BUSY, timeout_err=0.

Source files
------------

// File: rtl/iic_arbiter.sv
// iic_arbiter: two-port valid/ready arbiter that shares one iic_ctrl master.
// Port 0 is the boot-time register sequencer, port 1 a runtime client.
// A winner's command fields are latched and launched as a one-cycle
// wr_en/rd_en pulse. The fields stay stable until iic_ctrl's done_flag.
// The arbiter then returns done/read data to the owning port and forces
// a bus-free gap of GAP_CYCLES before the next accept.
// Optional feature macro: IIC_ARB_TIMEOUT_EN adds a BUSY watchdog that
// ends a hung transaction with a done + timeout_err pulse.

module iic_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int FIXED_PRIO  = 0,
   parameter int GAP_CYCLES  = 4,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              req0_valid,
   input  logic              req0_rd,
   input  logic [6:0]        req0_dev_addr,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic              req0_addr_num,
   input  logic [7:0]        req0_wdata,
   output logic              req0_ready,
   output logic              req0_done,
   output logic [7:0]        req0_rdata,

   input  logic              req1_valid,
   input  logic              req1_rd,
   input  logic [6:0]        req1_dev_addr,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic              req1_addr_num,
   input  logic [7:0]        req1_wdata,
   output logic              req1_ready,
   output logic              req1_done,
   output logic [7:0]        req1_rdata,

   output logic              timeout_err,

   output logic              iic_wr_en,
   output logic              iic_rd_en,
   output logic [6:0]        iic_dev_addr,
   output logic [ADDR_W-1:0] iic_addr,
   output logic              iic_addr_num,
   output logic [7:0]        iic_data,
   input  logic              iic_done_flag,
   input  logic [7:0]        iic_rd_data
);

   // Reject parameter values the 8-bit gap counter or the watchdog cannot honour.
   if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("iic_arbiter: GAP_CYCLES must be within 0..255");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("iic_arbiter: TIMEOUT_CYC must be at least 1");
   end

   localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              rd_q, rd_d;
   logic [6:0]        dev_q, dev_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              addr_num_q, addr_num_d;
   logic [7:0]        data_q, data_d;
   logic [7:0]        gap_q, gap_d;
   logic              done0_q, done0_d;
   logic              done1_q, done1_d;
   logic [7:0]        rdata0_q, rdata0_d;
   logic [7:0]        rdata1_q, rdata1_d;

   logic              grant0;
   logic              grant1;
   logic              accept;
   logic              finish;

`ifdef IIC_ARB_TIMEOUT_EN
   localparam int TCNT_W = ($clog2(TIMEOUT_CYC) > 20) ? $clog2(TIMEOUT_CYC) : 20;
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic              tout_q, tout_d;
   logic              expired;
`endif

   // Pick a winner in IDLE; ready is also held low while reset is asserted so
   // that every output is quiet during reset even if a requester is valid.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == ST_IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            if (FIXED_PRIO != 0) begin
               grant0 = 1'b1;
            end else if (last_grant_q) begin
               grant0 = 1'b1;
            end else begin
               grant1 = 1'b1;
            end
         end else if (req0_valid) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   assign accept = grant0 || grant1;

`ifdef IIC_ARB_TIMEOUT_EN
   assign expired = (state_q == ST_BUSY) && !iic_done_flag && (tcnt_q == TCNT_LAST);
   assign finish  = ((state_q == ST_BUSY) && iic_done_flag) || expired;
`else
   assign finish  = (state_q == ST_BUSY) && iic_done_flag;
`endif

   // Transaction sequencing: accept, launch, wait for completion, enforce bus-free gap.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (finish) begin
               gap_d   = GAP_LOAD;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Latch the winner's command fields at accept; they stay frozen until the next accept.
   always_comb begin
      owner_d    = owner_q;
      rd_d       = rd_q;
      dev_d      = dev_q;
      addr_d     = addr_q;
      addr_num_d = addr_num_q;
      data_d     = data_q;
      if (grant1) begin
         owner_d    = 1'b1;
         rd_d       = req1_rd;
         dev_d      = req1_dev_addr;
         addr_d     = req1_addr;
         addr_num_d = req1_addr_num;
         data_d     = req1_wdata;
      end else if (grant0) begin
         owner_d    = 1'b0;
         rd_d       = req0_rd;
         dev_d      = req0_dev_addr;
         addr_d     = req0_addr;
         addr_num_d = req0_addr_num;
         data_d     = req0_wdata;
      end
   end

   // Route completion, read data and grant history back to the owning port.
   always_comb begin
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      last_grant_d = last_grant_q;
      if (finish) begin
         done0_d      = !owner_q;
         done1_d      = owner_q;
         last_grant_d = owner_q;
      end
      if (state_q == ST_BUSY && iic_done_flag && rd_q) begin
         if (owner_q) begin
            rdata1_d = iic_rd_data;
         end else begin
            rdata0_d = iic_rd_data;
         end
      end
   end

`ifdef IIC_ARB_TIMEOUT_EN
   // Watchdog counts BUSY cycles from zero for every launched transaction.
   always_comb begin
      tcnt_d = tcnt_q;
      tout_d = expired;
      if (state_q == ST_ISSUE) begin
         tcnt_d = '0;
      end else if (state_q == ST_BUSY && !finish) begin
         tcnt_d = tcnt_q + 1'b1;
      end
   end

   // Watchdog registers; reset clears any partial count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_q <= '0;
         tout_q <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         tout_q <= tout_d;
      end
   end

   assign timeout_err = tout_q;
`else
   assign timeout_err = 1'b0;
`endif

   // State and datapath registers; reset aborts any transaction without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rd_q         <= 1'b0;
         dev_q        <= '0;
         addr_q       <= '0;
         addr_num_q   <= 1'b0;
         data_q       <= '0;
         gap_q        <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         rd_q         <= rd_d;
         dev_q        <= dev_d;
         addr_q       <= addr_d;
         addr_num_q   <= addr_num_d;
         data_q       <= data_d;
         gap_q        <= gap_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign req0_ready   = grant0;
   assign req1_ready   = grant1;
   assign req0_done    = done0_q;
   assign req1_done    = done1_q;
   assign req0_rdata   = rdata0_q;
   assign req1_rdata   = rdata1_q;

   assign iic_wr_en    = (state_q == ST_ISSUE) && !rd_q;
   assign iic_rd_en    = (state_q == ST_ISSUE) && rd_q;
   assign iic_dev_addr = dev_q;
   assign iic_addr     = addr_q;
   assign iic_addr_num = addr_num_q;
   assign iic_data     = data_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// tb_iic_arbiter: directed self-checking bench for iic_arbiter.
// Instance dut uses round-robin, instance fp uses fixed priority; both
// use GAP_CYCLES=4 and TIMEOUT_CYC=100.

module tb_iic_arbiter;

   localparam int ADDR_W = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic              req0_valid, req0_rd, req0_addr_num;
   logic [6:0]        req0_dev_addr;
   logic [ADDR_W-1:0] req0_addr;
   logic [7:0]        req0_wdata;
   logic              req0_ready, req0_done;
   logic [7:0]        req0_rdata;
   logic              req1_valid, req1_rd, req1_addr_num;
   logic [6:0]        req1_dev_addr;
   logic [ADDR_W-1:0] req1_addr;
   logic [7:0]        req1_wdata;
   logic              req1_ready, req1_done;
   logic [7:0]        req1_rdata;
   logic              timeout_err, iic_wr_en, iic_rd_en, iic_addr_num;
   logic [6:0]        iic_dev_addr;
   logic [ADDR_W-1:0] iic_addr;
   logic [7:0]        iic_data;
   logic              iic_done_flag;
   logic [7:0]        iic_rd_data;

   logic              fp_req0_valid, fp_req1_valid;
   logic              fp_req0_ready, fp_req0_done, fp_req1_ready, fp_req1_done;
   logic [7:0]        fp_req0_rdata, fp_req1_rdata;
   logic              fp_timeout_err, fp_iic_wr_en, fp_iic_rd_en, fp_iic_addr_num;
   logic [6:0]        fp_iic_dev_addr;
   logic [ADDR_W-1:0] fp_iic_addr;
   logic [7:0]        fp_iic_data;
   logic              fp_iic_done_flag;
   logic [6:0]        fp_dev0, fp_dev1;
   logic [ADDR_W-1:0] fp_addr0, fp_addr1;
   logic [7:0]        fp_wdata0, fp_wdata1;

   int tests_run    = 0;
   int tests_failed = 0;

   iic_arbiter #(.ADDR_W(ADDR_W), .FIXED_PRIO(0), .GAP_CYCLES(4), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_dev_addr(req0_dev_addr),
      .req0_addr(req0_addr), .req0_addr_num(req0_addr_num), .req0_wdata(req0_wdata),
      .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_dev_addr(req1_dev_addr),
      .req1_addr(req1_addr), .req1_addr_num(req1_addr_num), .req1_wdata(req1_wdata),
      .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata),
      .timeout_err(timeout_err), .iic_wr_en(iic_wr_en), .iic_rd_en(iic_rd_en),
      .iic_dev_addr(iic_dev_addr), .iic_addr(iic_addr), .iic_addr_num(iic_addr_num),
      .iic_data(iic_data), .iic_done_flag(iic_done_flag), .iic_rd_data(iic_rd_data)
   );

   iic_arbiter #(.ADDR_W(ADDR_W), .FIXED_PRIO(1), .GAP_CYCLES(4), .TIMEOUT_CYC(100)) fp (
      .clk(clk), .rst(rst),
      .req0_valid(fp_req0_valid), .req0_rd(1'b0), .req0_dev_addr(fp_dev0),
      .req0_addr(fp_addr0), .req0_addr_num(1'b0), .req0_wdata(fp_wdata0),
      .req0_ready(fp_req0_ready), .req0_done(fp_req0_done), .req0_rdata(fp_req0_rdata),
      .req1_valid(fp_req1_valid), .req1_rd(1'b0), .req1_dev_addr(fp_dev1),
      .req1_addr(fp_addr1), .req1_addr_num(1'b0), .req1_wdata(fp_wdata1),
      .req1_ready(fp_req1_ready), .req1_done(fp_req1_done), .req1_rdata(fp_req1_rdata),
      .timeout_err(fp_timeout_err), .iic_wr_en(fp_iic_wr_en), .iic_rd_en(fp_iic_rd_en),
      .iic_dev_addr(fp_iic_dev_addr), .iic_addr(fp_iic_addr), .iic_addr_num(fp_iic_addr_num),
      .iic_data(fp_iic_data), .iic_done_flag(fp_iic_done_flag), .iic_rd_data(8'h00)
   );

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Wait (from a post-edge point) for any ready on dut; n = cycles waited, bound 100.
   task automatic wait_grant(output int n);
      n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 100) begin
         cyc();
         n++;
         @(negedge clk);
      end
   endtask

   // Same as wait_grant for the fixed-priority instance.
   task automatic wait_grant_fp(output int n);
      n = 0;
      @(negedge clk);
      while (!(fp_req0_ready || fp_req1_ready) && n < 100) begin
         cyc();
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req0_rd = 1'b0; req0_dev_addr = '0; req0_addr = '0;
      req0_addr_num = 1'b0; req0_wdata = '0;
      req1_valid = 1'b0; req1_rd = 1'b0; req1_dev_addr = '0; req1_addr = '0;
      req1_addr_num = 1'b0; req1_wdata = '0;
      iic_done_flag = 1'b0; iic_rd_data = '0;
      fp_req0_valid = 1'b0; fp_req1_valid = 1'b0; fp_iic_done_flag = 1'b0;
      fp_dev0 = 7'h10; fp_dev1 = 7'h11; fp_addr0 = 16'h0010; fp_addr1 = 16'h0011;
      fp_wdata0 = 8'h20; fp_wdata1 = 8'h21;
      cyc(); cyc();
      req0_valid = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready, req0_done, req1_done, req0_rdata, req1_rdata, timeout_err,
           iic_wr_en, iic_rd_en, iic_dev_addr, iic_addr, iic_addr_num, iic_data} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: ready=%b%b done=%b%b wr=%b rd=%b dev=%h addr=%h data=%h, required all zero",
                  req0_ready, req1_ready, req0_done, req1_done, iic_wr_en, iic_rd_en, iic_dev_addr, iic_addr, iic_data);
      end
      cyc();
      req0_valid = 1'b0;
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_write_p0();
      int n;
      int bad;
      req0_rd = 1'b0; req0_dev_addr = 7'h1A; req0_addr = 16'h0000;
      req0_addr_num = 1'b0; req0_wdata = 8'h5C; req0_valid = 1'b1;
      wait_grant(n);
      tests_run++;
      if (n !== 0 || {req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL write_ready: ready=%b%b after %0d cycles, required 10 after 0", req0_ready, req1_ready, n);
      end
      cyc();
      req0_valid = 1'b0;
      req0_wdata = 8'hFF;
      @(negedge clk);
      tests_run++;
      if ({iic_wr_en, iic_rd_en, iic_dev_addr, iic_addr, iic_addr_num, iic_data} !==
          {1'b1, 1'b0, 7'h1A, 16'h0000, 1'b0, 8'h5C}) begin
         tests_failed++;
         $display("[TB] FAIL write_launch: wr=%b rd=%b dev=%h addr=%h num=%b data=%h, required 1 0 1a 0000 0 5c",
                  iic_wr_en, iic_rd_en, iic_dev_addr, iic_addr, iic_addr_num, iic_data);
      end
      bad = 0;
      for (int i = 1; i < 40; i++) begin
         cyc();
         @(negedge clk);
         if (iic_wr_en || iic_rd_en || req0_ready || req1_ready || req0_done ||
             iic_dev_addr !== 7'h1A || iic_addr !== 16'h0000 || iic_data !== 8'h5C) bad++;
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("[TB] FAIL write_busy_hold: %0d bad cycles, required 0", bad);
      end
      cyc();
      iic_done_flag = 1'b1;
      iic_rd_data = 8'hEE;
      @(negedge clk);
      tests_run++;
      if (req0_done !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL write_done_early: done0=%b in done_flag cycle, required 0", req0_done);
      end
      cyc();
      iic_done_flag = 1'b0;
      iic_rd_data = 8'h00;
      @(negedge clk);
      tests_run++;
      if ({req0_done, req1_done, req0_rdata} !== {1'b1, 1'b0, 8'h00}) begin
         tests_failed++;
         $display("[TB] FAIL write_done: done=%b%b rdata0=%h, required 10 rdata0=00", req0_done, req1_done, req0_rdata);
      end
      cyc();
      @(negedge clk);
      tests_run++;
      if (req0_done !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL write_done_width: done0=%b one cycle later, required 0", req0_done);
      end
   endtask

   task automatic test_read_p1();
      int n;
      cyc();
      req1_rd = 1'b1; req1_dev_addr = 7'h1A; req1_addr = 16'h0102;
      req1_addr_num = 1'b1; req1_wdata = 8'h00; req1_valid = 1'b1;
      wait_grant(n);
      tests_run++;
      if (n >= 100 || {req0_ready, req1_ready} !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL read_ready: ready=%b%b after %0d cycles, required 01", req0_ready, req1_ready, n);
      end
      cyc();
      req1_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({iic_wr_en, iic_rd_en, iic_dev_addr, iic_addr, iic_addr_num} !==
          {1'b0, 1'b1, 7'h1A, 16'h0102, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL read_launch: wr=%b rd=%b dev=%h addr=%h num=%b, required 0 1 1a 0102 1",
                  iic_wr_en, iic_rd_en, iic_dev_addr, iic_addr, iic_addr_num);
      end
      cyc();
      @(negedge clk);
      tests_run++;
      if ({iic_wr_en, iic_rd_en} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL read_pulse_width: wr=%b rd=%b next cycle, required 00", iic_wr_en, iic_rd_en);
      end
      cyc();
      cyc();
      iic_done_flag = 1'b1;
      iic_rd_data = 8'hA7;
      cyc();
      iic_done_flag = 1'b0;
      iic_rd_data = 8'h00;
      @(negedge clk);
      tests_run++;
      if ({req0_done, req1_done, req1_rdata, req0_rdata} !== {1'b0, 1'b1, 8'hA7, 8'h00}) begin
         tests_failed++;
         $display("[TB] FAIL read_done: done=%b%b rdata1=%h rdata0=%h, required 01 a7 00",
                  req0_done, req1_done, req1_rdata, req0_rdata);
      end
      cyc();
      @(negedge clk);
      tests_run++;
      if ({req1_done, req1_rdata} !== {1'b0, 8'hA7}) begin
         tests_failed++;
         $display("[TB] FAIL read_hold: done1=%b rdata1=%h, required 0 a7", req1_done, req1_rdata);
      end
   endtask

   task automatic test_round_robin();
      int n;
      logic [1:0] exp_rdy;
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      req0_rd = 1'b0; req0_dev_addr = 7'h1A; req0_addr = 16'h0004; req0_wdata = 8'h11;
      req1_rd = 1'b1; req1_dev_addr = 7'h1A; req1_addr = 16'h0005;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
         wait_grant(n);
         tests_run++;
         if ({req0_ready, req1_ready} !== exp_rdy || n !== ((i == 0) ? 0 : 4)) begin
            tests_failed++;
            $display("[TB] FAIL rr_grant%0d: ready=%b%b after %0d cycles, required %b after %0d",
                     i, req0_ready, req1_ready, n, exp_rdy, (i == 0) ? 0 : 4);
         end
         cyc();
         @(negedge clk);
         tests_run++;
         if ({iic_wr_en, iic_rd_en} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            tests_failed++;
            $display("[TB] FAIL rr_launch%0d: wr=%b rd=%b, required %s", i, iic_wr_en, iic_rd_en,
                     (i % 2 == 0) ? "wr" : "rd");
         end
         cyc();
         cyc();
         iic_done_flag = 1'b1;
         iic_rd_data = 8'h30 + 8'(i);
         cyc();
         iic_done_flag = 1'b0;
         iic_rd_data = 8'h00;
         @(negedge clk);
         tests_run++;
         if ({req0_done, req1_done} !== exp_rdy ||
             ((i % 2 == 1) && req1_rdata !== (8'h30 + 8'(i))) || req0_rdata !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL rr_done%0d: done=%b%b rdata1=%h rdata0=%h, required %b rdata0=00",
                     i, req0_done, req1_done, req1_rdata, req0_rdata, exp_rdy);
         end
         cyc();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_spurious_done();
      int n;
      iic_done_flag = 1'b1;
      cyc();
      iic_done_flag = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({req0_done, req1_done} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL spurious_gap: done=%b%b, required 00", req0_done, req1_done);
      end
      for (int i = 0; i < 10; i++) cyc();
      iic_done_flag = 1'b1;
      cyc();
      iic_done_flag = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({req0_done, req1_done} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL spurious_idle: done=%b%b, required 00", req0_done, req1_done);
      end
      cyc();
      req0_rd = 1'b0;
      req0_valid = 1'b1;
      wait_grant(n);
      tests_run++;
      if (n !== 0 || {req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL spurious_still_idle: ready=%b%b after %0d cycles, required 10 after 0",
                  req0_ready, req1_ready, n);
      end
      cyc();
      req0_valid = 1'b0;
      cyc();
      cyc();
      iic_done_flag = 1'b1;
      cyc();
      iic_done_flag = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({req0_done, req1_done} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL spurious_followup_done: done=%b%b, required 10", req0_done, req1_done);
      end
   endtask

   task automatic test_valid_drop();
      int bad;
      bad = 0;
      cyc();
      req1_valid = 1'b1;
      @(negedge clk);
      if (req0_ready || req1_ready) bad++;
      cyc();
      req1_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (req0_ready || req1_ready || iic_wr_en || iic_rd_en) bad++;
         cyc();
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("[TB] FAIL valid_drop: %0d cycles with ready or launch, required 0", bad);
      end
   endtask

   task automatic test_reset_mid_busy();
      int n;
      req0_rd = 1'b0; req0_dev_addr = 7'h22; req0_addr = 16'h0033; req0_wdata = 8'h44;
      req0_valid = 1'b1;
      wait_grant(n);
      cyc();
      req0_valid = 1'b0;
      cyc();
      cyc();
      rst = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({req0_ready, req1_ready, req0_done, req1_done, timeout_err, iic_wr_en, iic_rd_en,
           iic_dev_addr, iic_addr, iic_addr_num, iic_data, req0_rdata, req1_rdata} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_busy_outputs: ready=%b%b done=%b%b dev=%h addr=%h data=%h rdata=%h/%h, required all zero",
                  req0_ready, req1_ready, req0_done, req1_done, iic_dev_addr, iic_addr, iic_data, req0_rdata, req1_rdata);
      end
      cyc();
      cyc();
      rst = 1'b0;
      req1_valid = 1'b0;
      iic_done_flag = 1'b1;
      cyc();
      iic_done_flag = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({req0_done, req1_done} !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL reset_abort_done: done=%b%b after reset, required 00", req0_done, req1_done);
      end
      cyc();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      wait_grant(n);
      tests_run++;
      if (n !== 0 || {req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL reset_first_grant: ready=%b%b after %0d cycles, required 10 after 0",
                  req0_ready, req1_ready, n);
      end
      cyc();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      cyc();
      cyc();
      iic_done_flag = 1'b1;
      cyc();
      iic_done_flag = 1'b0;
      for (int i = 0; i < 8; i++) cyc();
   endtask

   task automatic test_fixed_prio();
      int n;
      fp_req0_valid = 1'b1;
      fp_req1_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_grant_fp(n);
         tests_run++;
         if ({fp_req0_ready, fp_req1_ready} !== 2'b10 || n !== ((i == 0) ? 0 : 4)) begin
            tests_failed++;
            $display("[TB] FAIL fp_grant%0d: ready=%b%b after %0d cycles, required 10 after %0d",
                     i, fp_req0_ready, fp_req1_ready, n, (i == 0) ? 0 : 4);
         end
         cyc();
         cyc();
         cyc();
         fp_iic_done_flag = 1'b1;
         cyc();
         fp_iic_done_flag = 1'b0;
         @(negedge clk);
         tests_run++;
         if ({fp_req0_done, fp_req1_done} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL fp_done%0d: done=%b%b, required 10", i, fp_req0_done, fp_req1_done);
         end
         cyc();
      end
      fp_req0_valid = 1'b0;
      wait_grant_fp(n);
      tests_run++;
      if ({fp_req0_ready, fp_req1_ready} !== 2'b01 || n !== 4) begin
         tests_failed++;
         $display("[TB] FAIL fp_port1_grant: ready=%b%b after %0d cycles, required 01 after 4",
                  fp_req0_ready, fp_req1_ready, n);
      end
      cyc();
      fp_req1_valid = 1'b0;
      cyc();
      cyc();
      fp_iic_done_flag = 1'b1;
      cyc();
      fp_iic_done_flag = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({fp_req0_done, fp_req1_done} !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL fp_port1_done: done=%b%b, required 01", fp_req0_done, fp_req1_done);
      end
      cyc();
   endtask

   task automatic test_timeout();
      int n;
      int first;
      int done_cnt;
      int tout_cnt;
      int ready_cnt;
      logic tout_at;
      logic [7:0] r0;
      r0 = req0_rdata;
      req0_rd = 1'b1;
      req0_valid = 1'b1;
      wait_grant(n);
      cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      first = 0; done_cnt = 0; tout_cnt = 0; ready_cnt = 0; tout_at = 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
      for (int k = 1; k <= 150; k++) begin
         cyc();
         iic_done_flag = (k == 103);
         iic_rd_data = (k == 103) ? 8'h99 : 8'h00;
         @(negedge clk);
         if (req0_done && first == 0) begin
            first = k;
            tout_at = timeout_err;
            tests_run++;
            if (req0_rdata !== r0) begin
               tests_failed++;
               $display("[TB] FAIL timeout_rdata: rdata0=%h, required unchanged %h", req0_rdata, r0);
            end
         end
         if (req0_done || req1_done) done_cnt++;
         if (timeout_err) tout_cnt++;
      end
      iic_done_flag = 1'b0;
      tests_run++;
      if (first !== 101 || tout_at !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_done: done0 at cycle %0d with timeout_err=%b, required cycle 101 with 1", first, tout_at);
      end
      tests_run++;
      if (done_cnt !== 1 || tout_cnt !== 1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_late_done: %0d done and %0d timeout pulses, required 1 and 1", done_cnt, tout_cnt);
      end
`else
      req1_valid = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         cyc();
         @(negedge clk);
         if (req0_done || req1_done) done_cnt++;
         if (timeout_err) tout_cnt++;
         if (req0_ready || req1_ready) ready_cnt++;
      end
      tests_run++;
      if (done_cnt !== 0 || tout_cnt !== 0 || ready_cnt !== 0) begin
         tests_failed++;
         $display("[TB] FAIL no_timeout_busy: %0d done, %0d timeout_err, %0d ready, required 0 0 0",
                  done_cnt, tout_cnt, ready_cnt);
      end
      cyc();
      req1_valid = 1'b0;
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
`endif
   endtask

   // Absolute time limit so the bench always terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      test_reset();
      test_write_p0();
      test_read_p1();
      test_round_robin();
      test_spurious_done();
      test_valid_drop();
      test_reset_mid_busy();
      test_fixed_prio();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
